// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with mid-bit sampling and a small
// first-word-fall-through receive FIFO.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   uart_rx    in   asynchronous serial line, idles high
//   rx_read    in   single-cycle pop of the FIFO head
//   err_clear  in   clears frame_err and overrun (a same-cycle set wins)
//   data       out  FIFO head byte, 8'h00 when empty
//   rx_valid   out  FIFO non-empty
//   rx_count   out  bytes held
//   rx_busy    out  frame in progress
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte arrived with FIFO full and no pop
module uart_rx_buffered #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_rx,
  input  logic                             rx_read,
  input  logic                             err_clear,
  output logic [7:0]                       data,
  output logic                             rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
  output logic                             rx_busy,
  output logic                             frame_err,
  output logic                             overrun
);

  localparam int unsigned CPB = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TW  = $clog2(CPB);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CPB - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- input synchronizer ----------------
  logic [1:0] r_sync;
  logic       r_rxs_d;
  logic       w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], uart_rx};
      r_rxs_d <= w_rxs;
    end
  end

  // ---------------- receive FSM ----------------
  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_ferr_evt;
  logic          r_busy;

  // Stop-bit outcome is registered as a strobe; the FIFO and the flags act
  // on it one cycle later, while the FSM is already back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_push     <= 1'b0;
      r_ferr_evt <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_ferr_evt <= 1'b0;
      r_busy     <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          // Only a 1->0 edge starts a frame, so a held-low line is ignored.
          if (r_rxs_d && !w_rxs) begin
            r_state <= S_START;
            r_tick  <= '0;
          end
        end
        S_START: begin
          if (r_tick == TICK_HALF) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_tick  <= '0;
              r_bit   <= '0;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_tick  <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            if (w_rxs) begin
              r_push <= 1'b1;
            end else begin
              r_ferr_evt <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovr_evt;

  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = rx_read && (r_count != '0);
  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_wr      = r_push && (!w_full || w_pop);
  assign w_ovr_evt = r_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- sticky error flags ----------------
  logic r_frame_err;
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_ferr_evt) begin
        r_frame_err <= 1'b1;
      end else if (err_clear) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (err_clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_count  = r_count;
  assign rx_valid  = (r_count != '0);
  assign data      = rx_valid ? r_mem[r_rd_ptr] : '0;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
